// File: rtl/wb16_arb_pkg.sv
// Shared types, Wishbone cycle-type codes and the round-robin pick function
// for the 16-bit Wishbone arbiter family.
package wb16_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam int MAX_N = 4;

    // One-hot winner: first requester found scanning from last+1 modulo n.
    function automatic logic [MAX_N-1:0] rr_pick(
        input logic [MAX_N-1:0] req,
        input logic [1:0]       last,
        input int               n
    );
        logic [MAX_N-1:0] g;
        logic [1:0]       idx;
        logic             found;
        g     = '0;
        found = 1'b0;
        for (int k = 1; k <= MAX_N; k++) begin
            if (k <= n) begin
                idx = 2'((int'(last) + k) % n);
                if (!found && req[idx]) begin
                    g[idx] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/wb16_rr_arbiter_pick.sv
// Combinational round-robin priority encoder: one-hot grant plus its binary
// index, reusable by any arbiter with up to four requesters.
module rr_pick_n
    import wb16_arb_pkg::*;
#(
    parameter int N = 2,
    localparam int LW = (N > 2) ? 2 : 1
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic [LW-1:0] idx
);

    logic [MAX_N-1:0] req_ext;
    logic [MAX_N-1:0] gnt_ext;

    always_comb begin
        req_ext        = '0;
        req_ext[N-1:0] = req;
        gnt_ext        = rr_pick(req_ext, 2'(last), N);
        gnt            = gnt_ext[N-1:0];
        idx            = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_ext[i]) idx = LW'(i);
        end
    end

endmodule

// File: rtl/wb16_rr_arbiter.sv
// Round-robin Wishbone arbiter: up to four masters share one slave port, with
// the grant held per bus cycle and a transfer quota enforced at burst boundaries.
module wb16_rr_arbiter
    import wb16_arb_pkg::*;
#(
    parameter int N     = 2,
    parameter int QUOTA = 16,
    parameter int AW    = 32,
    parameter int DW    = 16,
    localparam int SW   = DW / 8,
    localparam int LW   = (N > 2) ? 2 : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    s_cyc,
    input  logic [N-1:0]    s_stb,
    input  logic [N-1:0]    s_we,
    input  logic [N*AW-1:0] s_adr,
    input  logic [N*DW-1:0] s_dat_ms,
    input  logic [N*SW-1:0] s_sel,
    input  logic [N*3-1:0]  s_cti,
    input  logic [N*2-1:0]  s_bte,
    output logic [N-1:0]    s_ack,
    output logic [DW-1:0]   s_dat_sm,
    output logic            m_cyc,
    output logic            m_stb,
    output logic            m_we,
    output logic [AW-1:0]   m_adr,
    output logic [DW-1:0]   m_dat_ms,
    output logic [SW-1:0]   m_sel,
    output logic [2:0]      m_cti,
    output logic [1:0]      m_bte,
    input  logic            m_ack,
    input  logic [DW-1:0]   m_dat_sm,
    output logic [N-1:0]    gnt
);

    localparam logic [7:0]    QMAX     = 8'(QUOTA);
    localparam logic [7:0]    QLAST    = 8'(QUOTA - 1);
    localparam logic [LW-1:0] LAST_RST = LW'(N - 1);

    arb_state_t    state_reg, state_next;
    logic [N-1:0]  gnt_reg, gnt_next;
    logic [LW-1:0] last_reg, last_next;
    logic [7:0]    cnt_reg, cnt_next;

    logic [N-1:0]  pick_gnt;
    logic [LW-1:0] pick_idx;
    logic          acked;
    logic          boundary;
    logic          others_req;
    logic          force_rel;

    logic [AW-1:0] adr_a [N];
    logic [DW-1:0] dat_a [N];
    logic [SW-1:0] sel_a [N];
    logic [2:0]    cti_a [N];
    logic [1:0]    bte_a [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_slice
            assign adr_a[gi] = s_adr[gi*AW +: AW];
            assign dat_a[gi] = s_dat_ms[gi*DW +: DW];
            assign sel_a[gi] = s_sel[gi*SW +: SW];
            assign cti_a[gi] = s_cti[gi*3 +: 3];
            assign bte_a[gi] = s_bte[gi*2 +: 2];
        end
    endgenerate

    rr_pick_n #(.N(N)) u_pick (
        .req  (s_cyc),
        .last (last_reg),
        .gnt  (pick_gnt),
        .idx  (pick_idx)
    );

    // last_reg doubles as the granted index while in GRANT.
    always_comb begin
        m_cyc    = 1'b0;
        m_stb    = 1'b0;
        m_we     = 1'b0;
        m_adr    = '0;
        m_dat_ms = '0;
        m_sel    = '0;
        m_cti    = '0;
        m_bte    = '0;
        s_ack    = '0;
        if (state_reg == GRANT) begin
            m_cyc           = s_cyc[last_reg];
            m_stb           = s_stb[last_reg];
            m_we            = s_we[last_reg];
            m_adr           = adr_a[last_reg];
            m_dat_ms        = dat_a[last_reg];
            m_sel           = sel_a[last_reg];
            m_cti           = cti_a[last_reg];
            m_bte           = bte_a[last_reg];
            s_ack[last_reg] = m_ack;
        end
    end

    assign s_dat_sm = m_dat_sm;
    assign gnt      = gnt_reg;

    assign acked      = m_ack & m_stb;
    assign boundary   = (m_cti == CTI_CLASSIC) || (m_cti == CTI_EOB);
    assign others_req = |(s_cyc & ~gnt_reg);
    assign force_rel  = acked && (cnt_reg >= QLAST) && boundary && others_req;

    always_comb begin
        state_next = state_reg;
        gnt_next   = gnt_reg;
        last_next  = last_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (|s_cyc) begin
                    state_next = GRANT;
                    gnt_next   = pick_gnt;
                    last_next  = pick_idx;
                    cnt_next   = '0;
                end
            end
            GRANT: begin
                if (acked && (cnt_reg < QMAX)) cnt_next = cnt_reg + 8'd1;
                // A quota release leaves one dead cycle so the next winner
                // is chosen from a clean IDLE arbitration.
                if (!m_cyc || force_rel) begin
                    state_next = IDLE;
                    gnt_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                gnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            gnt_reg   <= '0;
            last_reg  <= LAST_RST;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            gnt_reg   <= gnt_next;
            last_reg  <= last_next;
            cnt_reg   <= cnt_next;
        end
    end

endmodule

// File: tb/tb_wb16_rr_arbiter.sv
// Self-checking bench for wb16_rr_arbiter (three masters, quota of four):
// a cycle table for basic arbitration plus scoreboarded multi-master runs.
module tb_wb16_rr_arbiter;
    import wb16_arb_pkg::*;

    localparam int N  = 3;
    localparam int Q  = 4;
    localparam int AW = 32;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    s_cyc, s_stb, s_we;
    logic [N*AW-1:0] s_adr;
    logic [N*DW-1:0] s_dat_ms;
    logic [N*2-1:0]  s_sel;
    logic [N*3-1:0]  s_cti;
    logic [N*2-1:0]  s_bte;
    logic [N-1:0]    s_ack;
    logic [DW-1:0]   s_dat_sm;
    logic            m_cyc, m_stb, m_we;
    logic [AW-1:0]   m_adr;
    logic [DW-1:0]   m_dat_ms;
    logic [1:0]      m_sel;
    logic [2:0]      m_cti;
    logic [1:0]      m_bte;
    logic            m_ack;
    logic [DW-1:0]   m_dat_sm;
    logic [N-1:0]    gnt;

    wb16_rr_arbiter #(.N(N), .QUOTA(Q), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
        .s_dat_ms(s_dat_ms), .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte),
        .s_ack(s_ack), .s_dat_sm(s_dat_sm),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
        .m_dat_ms(m_dat_ms), .m_sel(m_sel), .m_cti(m_cti), .m_bte(m_bte),
        .m_ack(m_ack), .m_dat_sm(m_dat_sm), .gnt(gnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0]  cyc;
        logic [2:0]  stb;
        logic [2:0]  cti;
        logic        ack;
        logic [15:0] dat;
        logic [2:0]  gnt;
        logic        mcyc;
        logic [2:0]  sack;
    } vec_t;
    vec_t tbl [12];

    typedef struct {
        int m;
        int k;
    } exp_t;
    exp_t          sb_q [$];
    logic [N-1:0]  gnt_log [$];
    logic [N-1:0]  exp_gnt_q [$];

    int          ntr  [N];
    int          done [N];
    logic        bst  [N];
    logic [31:0] base [N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] adr_of(input int m, input int k);
        return base[m] + 32'(2 * k);
    endfunction

    function automatic logic [15:0] dat_of(input int m, input int k);
        return 16'(adr_of(m, k)) + 16'(m);
    endfunction

    function automatic logic [2:0] cti_of(input int m, input int k);
        if (!bst[m]) return CTI_CLASSIC;
        return (k == ntr[m] - 1) ? CTI_EOB : CTI_INCR;
    endfunction

    function automatic logic [15:0] rd_data(input logic [31:0] a);
        return a[15:0] ^ 16'hA55A;
    endfunction

    task automatic push_seq(input int m, input int k0, input int k1);
        exp_t e;
        for (int k = k0; k <= k1; k++) begin
            e.m = m;
            e.k = k;
            sb_q.push_back(e);
        end
    endtask

    task automatic drive_masters();
        logic act;
        for (int i = 0; i < N; i++) begin
            act                 = (done[i] < ntr[i]);
            s_cyc[i]            = act;
            s_stb[i]            = act;
            s_we[i]             = (i == 1);
            s_adr[i*AW +: AW]   = adr_of(i, done[i]);
            s_dat_ms[i*DW +: DW] = dat_of(i, done[i]);
            s_sel[i*2 +: 2]     = 2'(i + 1);
            s_cti[i*3 +: 3]     = cti_of(i, done[i]);
            s_bte[i*2 +: 2]     = 2'(i);
        end
    endtask

    task automatic do_reset();
        for (int i = 0; i < N; i++) begin
            ntr[i]  = 0;
            done[i] = 0;
            bst[i]  = 1'b0;
            base[i] = 32'h1000 * 32'(i + 1);
        end
        drive_masters();
        m_ack    = 1'b0;
        m_dat_sm = '0;
        rst      = 1'b1;
        @(negedge clk);
        chk("reset_gnt", 64'(gnt), 64'(0));
        chk("reset_mcyc", 64'({m_cyc, m_stb, s_ack}), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Drives the master models with a zero-wait slave until every master has
    // finished; each ack is matched against the scoreboard.
    task automatic run_masters(input string tname, input int budget);
        int   cycles;
        bit   all_done;
        exp_t e;
        int   run;
        bit   seen;
        logic [N-1:0] c [$];
        gnt_log.delete();
        cycles   = 0;
        all_done = 1'b0;
        while (!all_done && cycles < budget) begin
            drive_masters();
            #1;
            m_ack    = m_cyc & m_stb;
            m_dat_sm = rd_data(m_adr);
            @(negedge clk);
            gnt_log.push_back(gnt);
            chk("ack_onehot", 64'($countones(s_ack) <= 1), 64'(1));
            for (int i = 0; i < N; i++) begin
                if (s_ack[i]) begin
                    chk("sb_nonempty", 64'(sb_q.size() != 0), 64'(1));
                    if (sb_q.size() != 0) begin
                        e = sb_q.pop_front();
                        $display("%s: ack m%0d adr=%h cti=%b rd=%h", tname, i, m_adr, m_cti, s_dat_sm);
                        chk("ack_master", 64'(i), 64'(e.m));
                        chk("fwd", 64'({m_adr, m_we, m_dat_ms, m_sel, m_cti, m_bte}),
                            64'({adr_of(e.m, e.k), e.m == 1, dat_of(e.m, e.k), 2'(e.m + 1),
                                 cti_of(e.m, e.k), 2'(e.m)}));
                        chk("rdata", 64'(s_dat_sm), 64'(rd_data(adr_of(e.m, e.k))));
                    end
                    done[i]++;
                end
            end
            all_done = 1'b1;
            for (int i = 0; i < N; i++) if (done[i] < ntr[i]) all_done = 1'b0;
            cycles++;
            @(posedge clk);
            #1;
        end
        m_ack = 1'b0;
        drive_masters();
        chk("budget", 64'(all_done), 64'(1));
        chk("sb_drained", 64'(sb_q.size()), 64'(0));
        sb_q.delete();
        for (int i = 0; i < gnt_log.size(); i++) begin
            if (c.size() == 0 || c[c.size()-1] != gnt_log[i]) c.push_back(gnt_log[i]);
        end
        while (c.size() > 0 && c[0] == '0) void'(c.pop_front());
        while (c.size() > 0 && c[c.size()-1] == '0) void'(c.pop_back());
        chk("gnt_seq_len", 64'(c.size()), 64'(exp_gnt_q.size()));
        for (int i = 0; i < c.size() && i < exp_gnt_q.size(); i++)
            chk("gnt_seq", 64'(c[i]), 64'(exp_gnt_q[i]));
        run  = 0;
        seen = 1'b0;
        for (int i = 0; i < gnt_log.size(); i++) begin
            if (gnt_log[i] == '0) run++;
            else begin
                if (seen && run > 0) chk("dead_len", 64'(run), 64'(1));
                run  = 0;
                seen = 1'b1;
            end
        end
        exp_gnt_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //              cyc     stb     cti  ack  dat       gnt     mcyc sack
        tbl[0]  = '{3'b000, 3'b000, 3'b000, 1'b0, 16'h0000, 3'b000, 1'b0, 3'b000};
        tbl[1]  = '{3'b011, 3'b011, 3'b000, 1'b0, 16'h1111, 3'b000, 1'b0, 3'b000};
        tbl[2]  = '{3'b011, 3'b011, 3'b000, 1'b1, 16'h1234, 3'b001, 1'b1, 3'b001};
        tbl[3]  = '{3'b011, 3'b011, 3'b000, 1'b1, 16'h2345, 3'b001, 1'b1, 3'b001};
        tbl[4]  = '{3'b011, 3'b011, 3'b000, 1'b1, 16'h3456, 3'b001, 1'b1, 3'b001};
        tbl[5]  = '{3'b010, 3'b010, 3'b000, 1'b0, 16'h0000, 3'b001, 1'b0, 3'b000};
        tbl[6]  = '{3'b010, 3'b010, 3'b000, 1'b0, 16'h0000, 3'b000, 1'b0, 3'b000};
        tbl[7]  = '{3'b010, 3'b010, 3'b000, 1'b1, 16'hBEEF, 3'b010, 1'b1, 3'b010};
        tbl[8]  = '{3'b000, 3'b000, 3'b000, 1'b0, 16'h0000, 3'b010, 1'b0, 3'b000};
        tbl[9]  = '{3'b000, 3'b100, 3'b000, 1'b0, 16'h0000, 3'b000, 1'b0, 3'b000};
        tbl[10] = '{3'b000, 3'b100, 3'b000, 1'b1, 16'h5555, 3'b000, 1'b0, 3'b000};
        tbl[11] = '{3'b000, 3'b100, 3'b000, 1'b0, 16'h0000, 3'b000, 1'b0, 3'b000};

        do_reset();
        for (int r = 0; r < 12; r++) begin
            s_cyc = tbl[r].cyc;
            s_stb = tbl[r].stb;
            s_cti = {tbl[r].cti, tbl[r].cti, tbl[r].cti};
            #1;
            m_ack    = tbl[r].ack;
            m_dat_sm = tbl[r].dat;
            @(negedge clk);
            $display("vec %0d: gnt=%b m_cyc=%b s_ack=%b s_dat_sm=%h", r, gnt, m_cyc, s_ack, s_dat_sm);
            chk("vec_gnt", 64'(gnt), 64'(tbl[r].gnt));
            chk("vec_mcyc", 64'(m_cyc), 64'(tbl[r].mcyc));
            chk("vec_sack", 64'(s_ack), 64'(tbl[r].sack));
            chk("vec_rdata", 64'(s_dat_sm), 64'(tbl[r].dat));
            @(posedge clk);
            #1;
        end

        // Asynchronous reset in the middle of a tenure, then round-robin restart.
        do_reset();
        s_cyc = 3'b011;
        s_stb = 3'b011;
        s_cti = '0;
        @(negedge clk);
        chk("rst_seq_idle", 64'(gnt), 64'(3'b000));
        @(posedge clk);
        #1;
        m_ack = 1'b1;
        @(negedge clk);
        chk("rst_seq_gnt", 64'(gnt), 64'(3'b001));
        chk("rst_seq_mcyc", 64'(m_cyc), 64'(1));
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_mcyc", 64'(m_cyc), 64'(0));
        chk("async_rst_gnt", 64'(gnt), 64'(0));
        chk("async_rst_sack", 64'(s_ack), 64'(0));
        @(posedge clk);
        #1;
        rst   = 1'b0;
        m_ack = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", 64'(gnt), 64'(3'b000));
        @(posedge clk);
        @(negedge clk);
        $display("reset sequence: regrant gnt=%b", gnt);
        chk("post_rst_m0_wins", 64'(gnt), 64'(3'b001));

        // Quota preemption: m0 classic x10 while m1 waits with two transfers.
        do_reset();
        ntr[0] = 10;
        ntr[1] = 2;
        push_seq(0, 0, 3);
        push_seq(1, 0, 1);
        push_seq(0, 4, 9);
        exp_gnt_q = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b001};
        run_masters("quota", 100);

        // Incrementing burst is never split, release follows the EOB beat.
        do_reset();
        ntr[0] = 8;
        bst[0] = 1'b1;
        ntr[1] = 1;
        push_seq(0, 0, 7);
        push_seq(1, 0, 0);
        exp_gnt_q = '{3'b001, 3'b000, 3'b010};
        run_masters("burst", 100);

        // Three continuous requesters rotate in strict round-robin order.
        do_reset();
        ntr[0] = 8;
        ntr[1] = 8;
        ntr[2] = 8;
        push_seq(0, 0, 3);
        push_seq(1, 0, 3);
        push_seq(2, 0, 3);
        push_seq(0, 4, 7);
        push_seq(1, 4, 7);
        push_seq(2, 4, 7);
        exp_gnt_q = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000,
                      3'b001, 3'b000, 3'b010, 3'b000, 3'b100};
        run_masters("rotate", 200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb16_rr_arbiter.md
Name: wb16_rr_arbiter

Overview:
- N-requester round-robin Wishbone arbiter. It shares one 16-bit / 32-bit-address Wishbone slave port between up to 4 masters, e.g. video read DMA, video write DMA and the CPU, in front of the SDRAM controller.
- Replaces ad-hoc two-master priority muxing with registered, fair grant sequencing and a per-tenure transfer quota.
- Grant is held for the whole bus cycle. It is forcibly released only on a transfer boundary, once the quota is used up and another master is waiting.

Parameters:
- N, 2, number of requesting masters (2..4).
- QUOTA, 16, max acked transfers per tenure before a forced release is allowed when others wait (1..255).
- AW, 32, address width.
- DW, 16, data width (byte lanes = DW/8).

Ports:
- clk  in  1  system clock, shared with all masters and the slave.
- rst  in  1  asynchronous, active-high reset.
- s_cyc  in  N  per-master cyc.
- s_stb  in  N  per-master stb.
- s_we  in  N  per-master we.
- s_adr  in  N*AW  per-master address, master i at bits [i*AW +: AW].
- s_dat_ms  in  N*DW  per-master write data.
- s_sel  in  N*DW/8  per-master byte selects.
- s_cti  in  N*3  per-master cycle type.
- s_bte  in  N*2  per-master burst type.
- s_ack  out  N  per-master ack.
- s_dat_sm  out  DW  read data, broadcast to all masters (valid only with that master's ack).
- m_cyc, m_stb, m_we  out  1 each  to the slave.
- m_adr  out  AW  to the slave.
- m_dat_ms  out  DW  to the slave.
- m_sel  out  DW/8  to the slave.
- m_cti  out  3  to the slave.
- m_bte  out  2  to the slave.
- m_ack  in  1  from the slave.
- m_dat_sm  in  DW  from the slave.
- gnt  out  N  one-hot current grant (debug/status).

Behaviour:

Reset:
- While rst is high: state=IDLE, gnt=0, last=N-1, ack_cnt=0.
- All m_* outputs and s_ack read 0; s_dat_sm = m_dat_sm (don't-care).
- Asserting rst mid-burst drops m_cyc immediately, combinationally through the async clear.

States:
- IDLE: gnt=0, m_cyc=m_stb=0.
  - If any s_cyc: winner = first i with s_cyc[i], scanning from last+1 modulo N.
  - Register gnt=onehot(winner), last=winner, ack_cnt=0, go to GRANT.
  - Arbitration latency: 1 clk from s_cyc to m_cyc.
- GRANT (g = granted index):
  - Combinational forwarding: m_* = s_*[g]; s_ack[g] = m_ack; s_ack[others] = 0.
  - Each m_ack increments ack_cnt, saturating at QUOTA.
  - Release when s_cyc[g]=0: go to IDLE next clk. m_cyc drops in the same cycle it drops at the master.
  - Forced release when all of the following hold in one cycle:
    - m_ack=1;
    - ack_cnt==QUOTA-1, or already saturated;
    - s_cti[g] is 3'b000 or 3'b111 (transfer boundary);
    - any other s_cyc is high.
  - On forced release: go to IDLE, then gnt=0 for that one dead cycle.
  - The preempted master sees no ack while stalled. It keeps cyc/stb and is re-arbitrated in round-robin order.
  - An incrementing burst (cti 3'b010) is never broken mid-burst, even beyond QUOTA.

Boundary conditions:
- Single requester: re-granted after each dead cycle; no starvation of itself.
- Simultaneous requests in IDLE: round-robin order strictly from last+1.
- New request arriving during GRANT: waits, with no effect on the current tenure unless the forced-release conditions are met.
- s_stb high with s_cyc low: ignored.
- m_ack with stb low: ignored (counted only when m_stb=1).

Decomposition:
- Package wb16_arb_pkg holds:
  - state enum {IDLE, GRANT};
  - localparams CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_EOB=3'b111;
  - function rr_pick(req, last) returning a one-hot grant.
- Sub-module rr_pick_n (combinational round-robin priority encoder, parameter N), reusable by other arbiters.
- The forwarding mux stays in the top module.

Test Plan:
- Reset mid-GRANT: assert rst while m0 bursts -> m_cyc=0 and gnt=0 the same cycle; after release, last=N-1, so m0 wins first.
- N=2, s_cyc=2'b11 set in the same cycle from reset -> gnt=01 one clk later. m0 does 3 classic acks then drops cyc -> one IDLE cycle, then gnt=10.
- QUOTA=4; m0 issues 10 classic transfers with m1 waiting:
  - after the 4th ack, gnt goes to 0 for one cycle, then to 10;
  - m0 receives no ack until m1 drops cyc;
  - m0 then resumes at its 5th address.
- QUOTA=4; m0 runs an 8-beat cti=010 burst ending in 111 while m1 waits -> all 8 acks go to m0 unbroken; release follows the EOB ack.
- N=3, all three cyc held continuously with QUOTA=1 -> grant sequence 001, 010, 100, 001, each separated by one dead cycle.
- Read data routing: with m1 granted, m_dat_sm=16'hBEEF and m_ack=1 -> s_ack=2'b10; s_dat_sm=16'hBEEF; s_ack[0] stays 0 throughout.
